// File: rtl/t05_sram_pkg.sv
// Shared constants and bus payload types for the compressor's Wishbone SRAM slave.
package t05_sram_pkg;
  localparam logic [31:0] SRAM_BASE_ADDR = 32'h3300_0000;
  localparam int unsigned SRAM_DEPTH     = 512;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned NUM_LANES      = 4;
  localparam int unsigned LANE_W         = WORD_W / NUM_LANES;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [NUM_LANES-1:0] sel_t;
endpackage

// File: rtl/t05_sram_bank.sv
// Single-port word array with byte-lane write enables and a registered read port.
module t05_sram_bank
  import t05_sram_pkg::*;
#(
  parameter int unsigned DEPTH = SRAM_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  sel_t          sel,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [DEPTH];

  // Writes touch only the selected lanes; rdata is reloaded on reads alone so it holds across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int k = 0; k < int'(NUM_LANES); k++) begin
          if (sel[k]) begin
            mem[addr][k*LANE_W +: LANE_W] <= wdata[k*LANE_W +: LANE_W];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/t05_sram_wb_slave.sv
// Wishbone classic slave over t05_sram_bank: address decode, request accept and
// a one-cycle registered acknowledge.
module t05_sram_wb_slave
  import t05_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = SRAM_BASE_ADDR,
  parameter int unsigned DEPTH     = SRAM_DEPTH,
  parameter int unsigned AW        = $clog2(DEPTH)
) (
  input  logic        hwclk,
  input  logic        reset,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  logic [31:0] offset;
  logic        in_range;
  logic        accept;
  logic        bank_en;
  logic        ack_q;
  logic        rd_valid_q;
  word_t       bank_rdata;
  logic        unused_adr_lsbs;

  // DEPTH is a power of two, so "offset < DEPTH*4" reduces to the high offset bits being zero.
  assign offset          = wbs_adr_i - BASE_ADDR;
  assign in_range        = (offset[31:AW+2] == '0);
  assign unused_adr_lsbs = ^offset[1:0];

  assign accept  = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign bank_en = accept & in_range & ~reset;

  t05_sram_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk   (hwclk),
    .en    (bank_en),
    .we    (wbs_we_i),
    .sel   (wbs_sel_i),
    .addr  (offset[AW+1:2]),
    .wdata (wbs_dat_i),
    .rdata (bank_rdata)
  );

  // rd_valid_q masks the un-resettable bank read register: clear on reset and on out-of-range reads.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      ack_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      ack_q <= accept;
      if (accept && !wbs_we_i) begin
        rd_valid_q <= in_range;
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rd_valid_q ? bank_rdata : 32'h0;

endmodule

// File: tb/tb_t05_sram_wb_slave.sv
// Self-checking bench for t05_sram_wb_slave against a word-array reference model.
module tb_t05_sram_wb_slave;
  import t05_sram_pkg::*;

  logic        hwclk = 1'b0;
  logic        reset = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [SRAM_DEPTH];
  logic [31:0] exp_dat = 32'h0;

  always #5 hwclk = ~hwclk;

  t05_sram_wb_slave dut (
    .hwclk     (hwclk),
    .reset     (reset),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o)
  );

  function automatic bit ref_in_range(input logic [31:0] adr);
    logic [31:0] off;
    off = adr - SRAM_BASE_ADDR;
    return off < SRAM_DEPTH * 4;
  endfunction

  function automatic int ref_index(input logic [31:0] adr);
    logic [31:0] off;
    off = adr - SRAM_BASE_ADDR;
    return int'(off / 4);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] adr);
    if (!ref_in_range(adr)) return 32'h0;
    return model[ref_index(adr)];
  endfunction

  task automatic ref_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] mask;
    if (!ref_in_range(adr)) return;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    model[ref_index(adr)] = (model[ref_index(adr)] & ~mask) | (dat & mask);
  endtask

  // One complete transfer; lat = negedges from request to ack (0 = timed out).
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output logic [31:0] rd, output int lat,
                      output logic ack_after);
    @(negedge hwclk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
    lat = 0; rd = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge hwclk);
      if (wbs_ack_o) begin lat = i; rd = wbs_dat_o; break; end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge hwclk);
    ack_after = wbs_ack_o;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge hwclk);
      checks++;
      if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_state: ack=%b dat=%h required ack=0 dat=00000000", wbs_ack_o, wbs_dat_o);
      end
    end
    reset = 1'b0;
    exp_dat = 32'h0;
    for (int i = 0; i < 6; i++) begin
      wbs_stb_i = (i % 2 == 0); wbs_cyc_i = (i % 2 == 1);
      @(negedge hwclk);
      checks++;
      if (wbs_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_ack: step %0d stb=%b cyc=%b ack=%b required 0", i, wbs_stb_i, wbs_cyc_i, wbs_ack_o);
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
  endtask

  // Writes every word so the model and the array agree before random traffic.
  task automatic test_fill;
    logic [31:0] rd, d;
    int lat;
    logic aa;
    for (int w = 0; w < int'(SRAM_DEPTH); w++) begin
      d = $urandom;
      xfer(1'b1, SRAM_BASE_ADDR + 32'(w * 4), 4'hF, d, rd, lat, aa);
      ref_write(SRAM_BASE_ADDR + 32'(w * 4), 4'hF, d);
      checks++;
      if (lat != 1 || aa !== 1'b0) begin
        errors++;
        $display("FAIL fill_ack: word %0d latency=%0d ack_after=%b required latency=1 ack_after=0", w, lat, aa);
      end
    end
  endtask

  task automatic test_full_write_read;
    logic [31:0] rd;
    int lat;
    logic aa;
    xfer(1'b1, 32'h3300_0010, 4'hF, 32'hDEAD_BEEF, rd, lat, aa);
    ref_write(32'h3300_0010, 4'hF, 32'hDEAD_BEEF);
    checks++;
    if (lat != 1 || aa !== 1'b0) begin
      errors++;
      $display("FAIL full_write_ack: latency=%0d ack_after=%b required 1/0", lat, aa);
    end
    xfer(1'b0, 32'h3300_0010, 4'h0, 32'h0, rd, lat, aa);
    exp_dat = 32'hDEAD_BEEF;
    checks++;
    if (lat != 1 || aa !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL full_read: latency=%0d ack_after=%b data=%h required 1/0/deadbeef", lat, aa, rd);
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd;
    int lat;
    logic aa;
    xfer(1'b1, 32'h3300_0020, 4'hF, 32'h1122_3344, rd, lat, aa);
    ref_write(32'h3300_0020, 4'hF, 32'h1122_3344);
    xfer(1'b1, 32'h3300_0022, 4'b0101, 32'hAABB_CCDD, rd, lat, aa);
    ref_write(32'h3300_0022, 4'b0101, 32'hAABB_CCDD);
    checks++;
    if (rd !== exp_dat) begin
      errors++;
      $display("FAIL write_keeps_dat: dat=%h required %h", rd, exp_dat);
    end
    xfer(1'b0, 32'h3300_0020, 4'h0, 32'h0, rd, lat, aa);
    exp_dat = 32'h11BB_33DD;
    checks++;
    if (lat != 1 || rd !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL byte_lanes: latency=%0d data=%h required 1/11bb33dd", lat, rd);
    end
  endtask

  task automatic test_back_to_back;
    int  idx;
    int  cyc;
    logic [31:0] exp;
    @(negedge hwclk);
    idx = 0;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    wbs_adr_i = SRAM_BASE_ADDR;
    for (cyc = 1; cyc <= 8; cyc++) begin
      @(negedge hwclk);
      checks++;
      if (wbs_ack_o !== (cyc % 2 == 1)) begin
        errors++;
        $display("FAIL b2b_ack_pattern: cycle %0d ack=%b required %b", cyc, wbs_ack_o, cyc % 2 == 1);
      end
      if (wbs_ack_o === 1'b1) begin
        exp = model[idx];
        checks++;
        if (wbs_dat_o !== exp) begin
          errors++;
          $display("FAIL b2b_data: word %0d data=%h required %h", idx, wbs_dat_o, exp);
        end
        exp_dat = exp;
        idx++;
        if (idx == 4) begin wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; end
        else wbs_adr_i = SRAM_BASE_ADDR + 32'(idx * 4);
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    checks++;
    if (idx != 4) begin
      errors++;
      $display("FAIL b2b_count: acks=%0d required 4", idx);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd, adr, w0;
    int lat;
    logic aa;
    adr = SRAM_BASE_ADDR + 32'(SRAM_DEPTH * 4);
    w0 = model[0];
    xfer(1'b1, adr, 4'hF, 32'h5555_5555, rd, lat, aa);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL oor_write_ack: latency=%0d required 1", lat);
    end
    xfer(1'b0, adr, 4'hF, 32'h0, rd, lat, aa);
    checks++;
    if (lat != 1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_read: latency=%0d data=%h required 1/00000000", lat, rd);
    end
    xfer(1'b0, SRAM_BASE_ADDR - 32'd4, 4'hF, 32'h0, rd, lat, aa);
    checks++;
    if (lat != 1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL below_base_read: latency=%0d data=%h required 1/00000000", lat, rd);
    end
    xfer(1'b0, SRAM_BASE_ADDR, 4'hF, 32'h0, rd, lat, aa);
    exp_dat = w0;
    checks++;
    if (rd !== w0) begin
      errors++;
      $display("FAIL oor_word0_intact: data=%h required %h", rd, w0);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, adr, dat, exp;
    logic [3:0]  sel;
    logic        we;
    int lat;
    logic aa;
    for (int n = 0; n < 300; n++) begin
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom);
      dat = $urandom;
      if ($urandom_range(0, 9) == 0) adr = $urandom;
      else adr = SRAM_BASE_ADDR + 32'($urandom_range(0, SRAM_DEPTH * 4 - 1));
      xfer(we, adr, sel, dat, rd, lat, aa);
      if (we) begin
        ref_write(adr, sel, dat);
        exp = exp_dat;
      end else begin
        exp = ref_read(adr);
        exp_dat = exp;
      end
      checks++;
      if (lat != 1 || aa !== 1'b0 || rd !== exp) begin
        errors++;
        $display("FAIL random_xfer: n=%0d we=%b adr=%h sel=%h latency=%0d ack_after=%b dat_o=%h required 1/0/%h",
                 n, we, adr, sel, lat, aa, rd, exp);
      end
      checks++;
      if (wbs_dat_o !== exp_dat) begin
        errors++;
        $display("FAIL idle_hold_dat: dat_o=%h required %h", wbs_dat_o, exp_dat);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] rd, adr;
    int lat;
    logic aa;
    adr = SRAM_BASE_ADDR + 32'h40;
    @(negedge hwclk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = adr;  wbs_sel_i = 4'hF; wbs_dat_i = 32'hCAFE_F00D;
    @(negedge hwclk);
    ref_write(adr, 4'hF, 32'hCAFE_F00D);
    checks++;
    if (wbs_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre_ack: ack=%b required 1", wbs_ack_o);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_async_clear: ack=%b dat=%h required 0/00000000", wbs_ack_o, wbs_dat_o);
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge hwclk);
    reset = 1'b0;
    exp_dat = 32'h0;
    // Write request held under reset across an edge must not commit.
    @(negedge hwclk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1; wbs_dat_i = 32'h0BAD_0BAD;
    #2 reset = 1'b1;
    @(negedge hwclk);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    reset = 1'b0;
    xfer(1'b0, adr, 4'h0, 32'h0, rd, lat, aa);
    exp_dat = model[ref_index(adr)];
    checks++;
    if (lat != 1 || rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL mid_reset_read: latency=%0d data=%h required 1/cafef00d", lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
